// File: rtl/trigger_issue_scheduler_pkg.sv
// Shared control definitions for the PE trigger/issue path.
package trigger_issue_scheduler_pkg;

  localparam int TIA_MAX_NUM_INSTRUCTIONS    = 16;
  localparam int TIA_INSTRUCTION_INDEX_WIDTH = $clog2(TIA_MAX_NUM_INSTRUCTIONS);

  typedef enum logic [1:0] {
    SCHED_DISABLED = 2'd0,
    SCHED_RUNNING  = 2'd1,
    SCHED_BUBBLE   = 2'd2,
    SCHED_HALTED   = 2'd3
  } sched_state_e;

endpackage

// File: rtl/trigger_issue_scheduler_priority_encoder.sv
// Lowest-index-wins priority encoder over the full instruction slot vector.
module trigger_resolution_priority_encoder
  import trigger_issue_scheduler_pkg::*;
(
  input  logic [TIA_MAX_NUM_INSTRUCTIONS-1:0]    triggers,
  output logic                                   found,
  output logic [TIA_INSTRUCTION_INDEX_WIDTH-1:0] index
);

  always_comb begin
    found = 1'b0;
    index = '0;
    // Scan downward so the last assignment is the lowest set bit.
    for (int i = TIA_MAX_NUM_INSTRUCTIONS - 1; i >= 0; i--) begin
      if (triggers[i]) begin
        found = 1'b1;
        index = TIA_INSTRUCTION_INDEX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/trigger_issue_scheduler.sv
// Per-PE issue sequencer: resolves triggers, issues under valid/ready,
// inserts hazard bubbles, handles enable/halt and keeps perf counters.
//
// state    | meaning
// DISABLED | PE not enabled; nothing issues
// RUNNING  | winner resolved and issued every cycle issue_ready allows
// BUBBLE   | dead cycles after a hazard instruction; triggers ignored
// HALTED   | halted; only enable=0 leaves
module trigger_issue_scheduler
  import trigger_issue_scheduler_pkg::*;
#(
  parameter int NUM_INSTRUCTIONS = TIA_MAX_NUM_INSTRUCTIONS,
  parameter int HAZARD_BUBBLES   = 1,
  parameter int COUNTER_WIDTH    = 32
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic                                   halt_request,
  input  logic [NUM_INSTRUCTIONS-1:0]            trigger_states,
  input  logic [NUM_INSTRUCTIONS-1:0]            instruction_hazards,
  input  logic                                   issue_ready,
  output logic                                   issue_valid,
  output logic [TIA_INSTRUCTION_INDEX_WIDTH-1:0] issue_index,
  output logic                                   halted,
  output logic [COUNTER_WIDTH-1:0]               issue_count,
  output logic [COUNTER_WIDTH-1:0]               stall_count
);

  localparam logic [1:0] S_DISABLED  = SCHED_DISABLED;
  localparam logic [1:0] S_RUNNING   = SCHED_RUNNING;
  localparam logic [1:0] S_BUBBLE    = SCHED_BUBBLE;
  localparam logic [1:0] S_HALTED    = SCHED_HALTED;
  localparam logic [2:0] BUBBLE_LOAD = 3'(HAZARD_BUBBLES);

  logic [1:0]                               state, state_next;
  logic [2:0]                               bubble_cnt, bubble_cnt_next;
  logic [TIA_MAX_NUM_INSTRUCTIONS-1:0]      triggers_ext, hazards_ext;
  logic                                     winner_found;
  logic [TIA_INSTRUCTION_INDEX_WIDTH-1:0]   winner_index;
  logic                                     issue_fire, stall_hit, running_ok;

  assign triggers_ext = TIA_MAX_NUM_INSTRUCTIONS'(trigger_states);
  assign hazards_ext  = TIA_MAX_NUM_INSTRUCTIONS'(instruction_hazards);

  trigger_resolution_priority_encoder u_prio (
    .triggers (triggers_ext),
    .found    (winner_found),
    .index    (winner_index)
  );

  assign running_ok = (state == S_RUNNING) && enable && !halt_request;
  assign issue_fire = running_ok && winner_found && issue_ready;
  assign stall_hit  = running_ok && winner_found && !issue_ready;

  always_comb begin
    state_next      = state;
    bubble_cnt_next = bubble_cnt;
    case (state)
      S_DISABLED: if (enable) state_next = S_RUNNING;
      S_RUNNING: begin
        if (!enable)                state_next = S_DISABLED;
        else if (halt_request)      state_next = S_HALTED;
        else if (issue_fire && hazards_ext[winner_index] && (BUBBLE_LOAD != 3'd0)) begin
          state_next      = S_BUBBLE;
          bubble_cnt_next = BUBBLE_LOAD;
        end
      end
      S_BUBBLE: begin
        if (!enable)                state_next = S_DISABLED;
        else if (halt_request)      state_next = S_HALTED;
        else if (bubble_cnt <= 3'd1) begin
          state_next      = S_RUNNING;
          bubble_cnt_next = 3'd0;
        end else begin
          bubble_cnt_next = bubble_cnt - 3'd1;
        end
      end
      default:    if (!enable) state_next = S_DISABLED;
    endcase
    // An abandoned bubble must not leak into a later hazard sequence.
    if (state_next != S_BUBBLE) bubble_cnt_next = 3'd0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_DISABLED;
      bubble_cnt  <= 3'd0;
      issue_valid <= 1'b0;
      issue_index <= '0;
      halted      <= 1'b0;
      issue_count <= '0;
      stall_count <= '0;
    end else begin
      state       <= state_next;
      bubble_cnt  <= bubble_cnt_next;
      issue_valid <= issue_fire;
      halted      <= (state_next == S_HALTED);
      if (issue_fire) issue_index <= winner_index;
      if (issue_fire && (issue_count != '1)) issue_count <= issue_count + COUNTER_WIDTH'(1);
      if (stall_hit && (stall_count != '1))  stall_count <= stall_count + COUNTER_WIDTH'(1);
    end
  end

endmodule
